mode_sequencer: RTL and testbench
=================================

# mode_sequencer

Registered, parametrised front-panel controller for the digital clock: owns the display mode (clock / stopwatch / alarm / spare) and a two-field manual-set state machine. It muxes the selected counter group onto the tube outputs and issues single-cycle hour/minute set pulses to the clock or alarm counters. It adds field blinking and an idle timeout. It sits between the debounced key pulses and the counter/display blocks.

## Interface
- FIELD_W, 7, width of every count field
- NUM_MODES, 3, number of active modes (legal 2..4); mode 0 CLOCK, 1 STOPWATCH, 2 ALARM, 3 SPARE
- TIMEOUT, 30, tick pulses of key inactivity before the set state is abandoned (legal 1..255)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- tick  in  1  one-cycle timebase pulse (1 Hz) for timeout counting
- blink_tick  in  1  one-cycle pulse toggling blink phase
- key_mode  in  1  one-cycle debounced pulse: next mode / abort set
- key_sel  in  1  one-cycle pulse: enter set / advance field
- key_inc  in  1  one-cycle pulse: increment selected field
- clock_hour_count, clock_min_count, clock_sec_count  in  FIELD_W each  clock value
- stopwatch_min_count, stopwatch_sec_count, stopwatch_hundredth_sec_count  in  FIELD_W each  stopwatch value
- alarm_hour_count, alarm_min_count, alarm_sec_count  in  FIELD_W each  alarm value
- tube_for  out  2  current mode
- set_state  out  2  0 NORMAL, 1 SET_HOUR, 2 SET_MIN
- display_hour, display_min, display_sec  out  FIELD_W each  registered display fields
- blank_hour, blank_min  out  1  blank request for the field being set
- clock_hour_set, clock_min_set, alarm_hour_set, alarm_min_set  out  1  one-cycle increment pulses

## Operation
- Reset: tube_for=0, set_state=NORMAL, idle counter=0, blink phase=0, all display fields 0, all blank and set outputs 0.
- Key priority when several keys arrive in one cycle: key_mode > key_sel > key_inc. Lower-priority keys in that cycle are dropped.
- NORMAL:
  - key_mode advances tube_for by 1; at NUM_MODES-1 it wraps to 0.
  - key_sel in CLOCK or ALARM enters SET_HOUR; in STOPWATCH or SPARE it is ignored.
  - key_inc is ignored.
- SET_HOUR:
  - key_inc pulses clock_hour_set if the mode is CLOCK, alarm_hour_set if ALARM.
  - key_sel goes to SET_MIN.
  - key_mode returns to NORMAL; tube_for is unchanged.
- SET_MIN: same as SET_HOUR with minute outputs; key_sel returns to NORMAL.
- Idle counter (8 bit):
  - Cleared on any key pulse and on entering NORMAL.
  - In a set state it increments on each tick; reaching TIMEOUT forces NORMAL.
  - A key in the same cycle as the terminal tick wins: the counter clears and no exit occurs.
- Blink:
  - The phase toggles on blink_tick.
  - It is forced to 0 on entering a set state and on every key_inc, so the field is visible while being adjusted.
  - blank_hour = SET_HOUR & phase; blank_min = SET_MIN & phase.
- Display mux per tube_for:
  - CLOCK: hour/min/sec.
  - STOPWATCH: min/sec/hundredth onto hour/min/sec.
  - ALARM: alarm hour/min/sec.
  - SPARE: zeros.
- Set outputs are never asserted outside SET_HOUR/SET_MIN. At most one set output is high per cycle.

## Timing
- Keys are sampled on the rising edge. tube_for and set_state change the cycle after the key pulse.
- Display fields are registered from the current tube_for and inputs: 1-cycle input-to-output latency, 2 cycles from key_mode.
- A set pulse is high exactly one cycle, the cycle after the sampled key_inc. Back-to-back key_inc pulses give back-to-back set pulses.
- Timeout exit: set_state reads NORMAL the cycle after the TIMEOUT-th tick with no intervening key.
- rst mid-set: all outputs clear immediately. No set pulse is emitted during or after reset.

## Test plan
- Reset, then key_mode ×4 with NUM_MODES=3 -> tube_for 1,2,0,1; display_hour equals stopwatch_min_count 2 cycles after first pulse.
- tube_for=0, key_sel, key_inc ×3, key_sel, key_inc, key_sel -> three single-cycle clock_hour_set, one clock_min_set, set_state ends NORMAL, no alarm pulses.
- tube_for=1, key_sel then key_inc -> set_state stays NORMAL, no set pulses.
- tube_for=2, key_sel, then 30 ticks with no keys (TIMEOUT=30) -> NORMAL after the 30th; repeat with key_inc on tick 29 -> remains SET_HOUR.
- In SET_HOUR assert key_mode, key_sel, key_inc together -> NORMAL, tube_for unchanged, no set pulse; blank_hour toggles with blink_tick and drops to 0 on key_inc.
- Assert rst while in SET_MIN with key_inc pending -> all outputs 0, tube_for 0, no pulse after release.

Source files
------------

// File: rtl/mode_sequencer.sv
// -----------------------------------------------------------------------------
// mode_sequencer
//
// Front-panel controller for the digital clock. Owns the display mode
// (CLOCK / STOPWATCH / ALARM / SPARE) and a two-field manual-set state
// machine. It registers the selected counter group onto the tube outputs,
// issues single-cycle hour/minute increment pulses to the clock or alarm
// counters, blinks the field being set and abandons the set state after a
// period of key inactivity.
//
// Parameters
//   FIELD_W    width of every count field
//   NUM_MODES  number of active modes (2..4)
//   TIMEOUT    tick pulses of key inactivity before set state is left (1..255)
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   tick                             1 Hz timebase pulse (idle timeout)
//   blink_tick                       blink phase toggle pulse
//   key_mode, key_sel, key_inc       debounced single-cycle key pulses
//   clock_*_count                    current clock value
//   stopwatch_*_count                current stopwatch value
//   alarm_*_count                    current alarm value
//   tube_for                         current display mode
//   set_state                        0 NORMAL, 1 SET_HOUR, 2 SET_MIN
//   display_hour/min/sec             registered display fields
//   blank_hour, blank_min            blank request for the field being set
//   clock_/alarm_ hour/min _set      single-cycle increment pulses
// -----------------------------------------------------------------------------
module mode_sequencer #(
    parameter int FIELD_W   = 7,
    parameter int NUM_MODES = 3,
    parameter int TIMEOUT   = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               blink_tick,
    input  logic               key_mode,
    input  logic               key_sel,
    input  logic               key_inc,
    input  logic [FIELD_W-1:0] clock_hour_count,
    input  logic [FIELD_W-1:0] clock_min_count,
    input  logic [FIELD_W-1:0] clock_sec_count,
    input  logic [FIELD_W-1:0] stopwatch_min_count,
    input  logic [FIELD_W-1:0] stopwatch_sec_count,
    input  logic [FIELD_W-1:0] stopwatch_hundredth_sec_count,
    input  logic [FIELD_W-1:0] alarm_hour_count,
    input  logic [FIELD_W-1:0] alarm_min_count,
    input  logic [FIELD_W-1:0] alarm_sec_count,
    output logic [1:0]         tube_for,
    output logic [1:0]         set_state,
    output logic [FIELD_W-1:0] display_hour,
    output logic [FIELD_W-1:0] display_min,
    output logic [FIELD_W-1:0] display_sec,
    output logic               blank_hour,
    output logic               blank_min,
    output logic               clock_hour_set,
    output logic               clock_min_set,
    output logic               alarm_hour_set,
    output logic               alarm_min_set
);

    // Display modes
    localparam logic [1:0] MODE_CLOCK     = 2'd0;
    localparam logic [1:0] MODE_STOPWATCH = 2'd1;
    localparam logic [1:0] MODE_ALARM     = 2'd2;
    localparam logic [1:0] MODE_SPARE     = 2'd3;

    // Set-state encoding (visible on set_state)
    localparam logic [1:0] ST_NORMAL   = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;

    localparam logic [1:0] LAST_MODE = 2'(NUM_MODES - 1);
    // Idle count value at which the next tick is the TIMEOUT-th one
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [1:0]         mode_q,  mode_d;
    logic [1:0]         state_q, state_d;
    logic [7:0]         idle_q,  idle_d;
    logic               phase_q, phase_d;
    logic [FIELD_W-1:0] disp_hour_q, disp_hour_d;
    logic [FIELD_W-1:0] disp_min_q,  disp_min_d;
    logic [FIELD_W-1:0] disp_sec_q,  disp_sec_d;
    logic               clock_hour_set_q, clock_hour_set_d;
    logic               clock_min_set_q,  clock_min_set_d;
    logic               alarm_hour_set_q, alarm_hour_set_d;
    logic               alarm_min_set_q,  alarm_min_set_d;

    // -------------------------------------------------------------------------
    // Key decode with priority key_mode > key_sel > key_inc; lower-priority
    // keys arriving in the same cycle are dropped.
    // -------------------------------------------------------------------------
    logic mode_key;
    logic sel_key;
    logic inc_key;
    logic any_key;
    logic in_set;
    logic settable;
    logic timeout_hit;
    logic enter_set;

    always_comb begin
        mode_key = key_mode;
        sel_key  = key_sel & ~key_mode;
        inc_key  = key_inc & ~key_mode & ~key_sel;
        any_key  = key_mode | key_sel | key_inc;
        in_set   = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
        settable = (mode_q == MODE_CLOCK) || (mode_q == MODE_ALARM);
        // Any key in the terminal-tick cycle resets the count instead of exiting
        timeout_hit = in_set && tick && !any_key && (idle_q == IDLE_LAST);
    end

    // -------------------------------------------------------------------------
    // Mode and set-state machine
    // -------------------------------------------------------------------------
    always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (mode_key) begin
                    mode_d = (mode_q == LAST_MODE) ? MODE_CLOCK : mode_q + 2'd1;
                end else if (sel_key && settable) begin
                    state_d = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR: begin
                if (mode_key) begin
                    state_d = ST_NORMAL;
                end else if (sel_key) begin
                    state_d = ST_SET_MIN;
                end else if (timeout_hit) begin
                    state_d = ST_NORMAL;
                end
            end
            ST_SET_MIN: begin
                if (mode_key || sel_key || timeout_hit) begin
                    state_d = ST_NORMAL;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Idle counter: only runs while a field is being set
    // -------------------------------------------------------------------------
    always_comb begin
        idle_d = idle_q;
        if (any_key || (state_d == ST_NORMAL)) begin
            idle_d = 8'd0;
        end else if (in_set && tick) begin
            idle_d = idle_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Blink phase: forced visible on entering a set state and on each
    // increment so the user sees the value being adjusted.
    // -------------------------------------------------------------------------
    always_comb begin
        enter_set = (state_q == ST_NORMAL) && (state_d == ST_SET_HOUR);
        phase_d   = phase_q;
        if (enter_set || inc_key) begin
            phase_d = 1'b0;
        end else if (blink_tick) begin
            phase_d = ~phase_q;
        end
    end

    // -------------------------------------------------------------------------
    // Increment pulses: one per accepted key_inc, routed by field and mode.
    // The states and modes are mutually exclusive so at most one fires.
    // -------------------------------------------------------------------------
    always_comb begin
        clock_hour_set_d = inc_key && (state_q == ST_SET_HOUR) && (mode_q == MODE_CLOCK);
        alarm_hour_set_d = inc_key && (state_q == ST_SET_HOUR) && (mode_q == MODE_ALARM);
        clock_min_set_d  = inc_key && (state_q == ST_SET_MIN)  && (mode_q == MODE_CLOCK);
        alarm_min_set_d  = inc_key && (state_q == ST_SET_MIN)  && (mode_q == MODE_ALARM);
    end

    // -------------------------------------------------------------------------
    // Display mux, selected by the current (registered) mode
    // -------------------------------------------------------------------------
    always_comb begin
        disp_hour_d = '0;
        disp_min_d  = '0;
        disp_sec_d  = '0;
        case (mode_q)
            MODE_CLOCK: begin
                disp_hour_d = clock_hour_count;
                disp_min_d  = clock_min_count;
                disp_sec_d  = clock_sec_count;
            end
            MODE_STOPWATCH: begin
                disp_hour_d = stopwatch_min_count;
                disp_min_d  = stopwatch_sec_count;
                disp_sec_d  = stopwatch_hundredth_sec_count;
            end
            MODE_ALARM: begin
                disp_hour_d = alarm_hour_count;
                disp_min_d  = alarm_min_count;
                disp_sec_d  = alarm_sec_count;
            end
            MODE_SPARE: begin
                disp_hour_d = '0;
                disp_min_d  = '0;
                disp_sec_d  = '0;
            end
            default: begin
                disp_hour_d = '0;
                disp_min_d  = '0;
                disp_sec_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q           <= MODE_CLOCK;
            state_q          <= ST_NORMAL;
            idle_q           <= 8'd0;
            phase_q          <= 1'b0;
            disp_hour_q      <= '0;
            disp_min_q       <= '0;
            disp_sec_q       <= '0;
            clock_hour_set_q <= 1'b0;
            clock_min_set_q  <= 1'b0;
            alarm_hour_set_q <= 1'b0;
            alarm_min_set_q  <= 1'b0;
        end else begin
            mode_q           <= mode_d;
            state_q          <= state_d;
            idle_q           <= idle_d;
            phase_q          <= phase_d;
            disp_hour_q      <= disp_hour_d;
            disp_min_q       <= disp_min_d;
            disp_sec_q       <= disp_sec_d;
            clock_hour_set_q <= clock_hour_set_d;
            clock_min_set_q  <= clock_min_set_d;
            alarm_hour_set_q <= alarm_hour_set_d;
            alarm_min_set_q  <= alarm_min_set_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tube_for       = mode_q;
    assign set_state      = state_q;
    assign display_hour   = disp_hour_q;
    assign display_min    = disp_min_q;
    assign display_sec    = disp_sec_q;
    assign blank_hour     = (state_q == ST_SET_HOUR) & phase_q;
    assign blank_min      = (state_q == ST_SET_MIN)  & phase_q;
    assign clock_hour_set = clock_hour_set_q;
    assign clock_min_set  = clock_min_set_q;
    assign alarm_hour_set = alarm_hour_set_q;
    assign alarm_min_set  = alarm_min_set_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mode_sequencer
//
// Directed bench for mode_sequencer (FIELD_W=7, NUM_MODES=3, TIMEOUT=30).
// Expected set pulses are queued when key_inc is issued; a monitor pops and
// compares whenever any set output is high. State/display values are
// checked directly against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mode_sequencer;

    localparam int FW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick, blink_tick, key_mode, key_sel, key_inc;
    logic [FW-1:0] ch, cm, cs, sm, ss, sh, ah, am, as_;
    logic [1:0]    tube_for, set_state;
    logic [FW-1:0] display_hour, display_min, display_sec;
    logic          blank_hour, blank_min;
    logic          clock_hour_set, clock_min_set, alarm_hour_set, alarm_min_set;

    int n_checks = 0;
    int n_fail   = 0;

    // {alarm_min, alarm_hour, clock_min, clock_hour}
    logic [3:0] exp_q[$];
    logic [3:0] mon_p, mon_e;

    mode_sequencer #(.FIELD_W(FW), .NUM_MODES(3), .TIMEOUT(30)) dut (
        .clk(clk), .rst(rst), .tick(tick), .blink_tick(blink_tick),
        .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
        .clock_hour_count(ch), .clock_min_count(cm), .clock_sec_count(cs),
        .stopwatch_min_count(sm), .stopwatch_sec_count(ss),
        .stopwatch_hundredth_sec_count(sh),
        .alarm_hour_count(ah), .alarm_min_count(am), .alarm_sec_count(as_),
        .tube_for(tube_for), .set_state(set_state),
        .display_hour(display_hour), .display_min(display_min),
        .display_sec(display_sec),
        .blank_hour(blank_hour), .blank_min(blank_min),
        .clock_hour_set(clock_hour_set), .clock_min_set(clock_min_set),
        .alarm_hour_set(alarm_hour_set), .alarm_min_set(alarm_min_set)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a set pulse must match the next queued entry
    always @(negedge clk) begin
        mon_p = {alarm_min_set, alarm_hour_set, clock_min_set, clock_hour_set};
        if (mon_p !== 4'b0000) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL set_pulse: got %b expected none", mon_p);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_p !== mon_e) begin
                    n_fail++;
                    $display("FAIL set_pulse: got %b expected %b", mon_p, mon_e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, sampled on the next rising edge
    task automatic press(input logic m, input logic s, input logic i,
                         input logic tk, input logic bt);
        key_mode = m; key_sel = s; key_inc = i; tick = tk; blink_tick = bt;
        @(posedge clk); #1;
        key_mode = 0; key_sel = 0; key_inc = 0; tick = 0; blink_tick = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; tick = 0; blink_tick = 0; key_mode = 0; key_sel = 0; key_inc = 0;
        ch = 7'd23; cm = 7'd45; cs = 7'd12;
        sm = 7'd7;  ss = 7'd8;  sh = 7'd99;
        ah = 7'd6;  am = 7'd30; as_ = 7'd5;
        step(); step();

        // Reset state
        check("rst_tube_for", 32'(tube_for), 0);
        check("rst_set_state", 32'(set_state), 0);
        check("rst_display_hour", 32'(display_hour), 0);
        check("rst_blank", 32'({blank_hour, blank_min}), 0);
        rst = 0;
        step();
        check("clock_disp_hour", 32'(display_hour), 23);
        check("clock_disp_sec", 32'(display_sec), 12);

        // Mode cycling 1,2,0,1 with display following two cycles after key
        press(1, 0, 0, 0, 0);
        check("mode1", 32'(tube_for), 1);
        step();
        check("sw_disp_hour", 32'(display_hour), 7);
        check("sw_disp_sec", 32'(display_sec), 99);
        press(1, 0, 0, 0, 0);
        check("mode2", 32'(tube_for), 2);
        step();
        check("alarm_disp_hour", 32'(display_hour), 6);
        check("alarm_disp_min", 32'(display_min), 30);
        press(1, 0, 0, 0, 0);
        check("mode_wrap0", 32'(tube_for), 0);
        press(1, 0, 0, 0, 0);
        check("mode1_again", 32'(tube_for), 1);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        check("mode0", 32'(tube_for), 0);

        // Clock set: three hour increments, one minute increment
        press(0, 1, 0, 0, 0);
        check("clk_set_hour", 32'(set_state), 1);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4'b0001);
            press(0, 0, 1, 0, 0);
        end
        press(0, 1, 0, 0, 0);
        check("clk_set_min", 32'(set_state), 2);
        exp_q.push_back(4'b0010);
        press(0, 0, 1, 0, 0);
        press(0, 1, 0, 0, 0);
        check("clk_set_done", 32'(set_state), 0);
        check("clk_mode_kept", 32'(tube_for), 0);

        // Stopwatch: sel and inc ignored
        press(1, 0, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        check("sw_no_set", 32'(set_state), 0);
        press(0, 0, 1, 0, 0);
        step();
        check("sw_still_normal", 32'(set_state), 0);

        // Alarm: idle timeout after exactly 30 ticks
        press(1, 0, 0, 0, 0);
        check("mode_alarm", 32'(tube_for), 2);
        press(0, 1, 0, 0, 0);
        check("alm_set_hour", 32'(set_state), 1);
        for (int k = 0; k < 29; k++) press(0, 0, 0, 1, 0);
        check("timeout_29", 32'(set_state), 1);
        press(0, 0, 0, 1, 0);
        check("timeout_30", 32'(set_state), 0);

        // key_inc on tick 29 restarts the idle count
        press(0, 1, 0, 0, 0);
        for (int k = 0; k < 28; k++) press(0, 0, 0, 1, 0);
        exp_q.push_back(4'b0100);
        press(0, 0, 1, 1, 0);
        press(0, 0, 0, 1, 0);
        check("timeout_key_wins", 32'(set_state), 1);
        for (int k = 0; k < 28; k++) press(0, 0, 0, 1, 0);
        check("timeout_restart_29", 32'(set_state), 1);
        press(0, 0, 0, 1, 0);
        check("timeout_restart_30", 32'(set_state), 0);

        // Blink and simultaneous-key priority in alarm SET_HOUR
        press(0, 1, 0, 0, 0);
        check("blink_enter", 32'(blank_hour), 0);
        press(0, 0, 0, 0, 1);
        check("blink_on", 32'(blank_hour), 1);
        press(0, 0, 0, 0, 1);
        check("blink_off", 32'(blank_hour), 0);
        press(0, 0, 0, 0, 1);
        check("blink_on2", 32'(blank_hour), 1);
        exp_q.push_back(4'b0100);
        press(0, 0, 1, 0, 0);
        check("blink_inc_clear", 32'(blank_hour), 0);
        press(0, 0, 0, 0, 1);
        check("blink_on3", 32'(blank_hour), 1);
        press(1, 1, 1, 0, 0);
        check("prio_normal", 32'(set_state), 0);
        check("prio_mode_kept", 32'(tube_for), 2);
        check("prio_blank", 32'({blank_hour, blank_min}), 0);

        // Reset while in SET_MIN with key_inc pending
        press(0, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        check("pre_rst_set_min", 32'(set_state), 2);
        key_inc = 1;
        rst = 1;
        #1;
        check("rst_mid_tube", 32'(tube_for), 0);
        check("rst_mid_state", 32'(set_state), 0);
        check("rst_mid_disp", 32'({display_hour, display_min, display_sec}), 0);
        check("rst_mid_pulses",
              32'({clock_hour_set, clock_min_set, alarm_hour_set, alarm_min_set}), 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        key_inc = 0;
        step(); step();
        check("post_rst_state", 32'(set_state), 0);
        check("post_rst_tube", 32'(tube_for), 0);

        // All queued pulses must have been observed
        check("pending_pulses", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
